// File: rtl/ysyx_23060020_wbu.sv
// Writeback unit: last stage before the register file.
// Retires one instruction at a time from EXU. ALU results write back the cycle
// after acceptance. Loads park in WAIT_LD until the LSU answers, then the raw
// word is byte/half selected, extended and written the following cycle.
// Exposes busy/rd hints so earlier stages can detect hazards on the held rd.
module ysyx_23060020_wbu #(
   parameter int          XLEN   = 32,
   parameter logic [31:0] RST_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [4:0]      in_rd,
   input  logic            in_wen,
   input  logic [XLEN-1:0] in_data,
   input  logic            in_is_load,
   input  logic [2:0]      in_ld_func,
   input  logic [1:0]      in_addr_lo,
   input  logic            lsu_rvalid,
   output logic            lsu_rready,
   input  logic [XLEN-1:0] lsu_rdata,
   input  logic            lsu_rerr,
   output logic            rfwen,
   output logic [4:0]      w1a,
   output logic [XLEN-1:0] w1d,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic            load_err,
   output logic            wb_busy,
   output logic [4:0]      wb_rd
);

   // IDLE: nothing held. WAIT_LD: load waiting on LSU data. WRITE: single
   // cycle in which the held instruction commits and writes the RF.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LD = 2'd1,
      WRITE   = 2'd2
   } state_t;

   // Load funct3 encodings handled by the extension logic.
   localparam logic [2:0] FUNC_LB  = 3'b000;
   localparam logic [2:0] FUNC_LH  = 3'b001;
   localparam logic [2:0] FUNC_LBU = 3'b100;
   localparam logic [2:0] FUNC_LHU = 3'b101;

   state_t          state_q,   state_d;
   logic [XLEN-1:0] pc_q,      pc_d;
   logic [4:0]      rd_q,      rd_d;
   logic            wen_q,     wen_d;
   logic [XLEN-1:0] data_q,    data_d;
   logic [2:0]      func_q,    func_d;
   logic [1:0]      lo_q,      lo_d;
   logic            err_q,     err_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;

   logic accept;

   // Selects the addressed byte or halfword out of the aligned memory word
   // and extends it. The halfword uses only address bit 1, so a misaligned
   // LH/LHU simply reads the halfword containing the address. LW and unused
   // funct3 codes return the word untouched.
   function automatic logic [XLEN-1:0] loadExtend(input logic [2:0]      func,
                                                  input logic [1:0]      lo,
                                                  input logic [XLEN-1:0] word);
      logic [7:0]      byteSel;
      logic [15:0]     halfSel;
      logic [XLEN-1:0] result;
      case (lo)
         2'd0:    byteSel = word[7:0];
         2'd1:    byteSel = word[15:8];
         2'd2:    byteSel = word[23:16];
         default: byteSel = word[31:24];
      endcase
      halfSel = lo[1] ? word[31:16] : word[15:0];
      case (func)
         FUNC_LB:  result = {{24{byteSel[7]}}, byteSel};
         FUNC_LBU: result = {24'd0, byteSel};
         FUNC_LH:  result = {{16{halfSel[15]}}, halfSel};
         FUNC_LHU: result = {16'd0, halfSel};
         default:  result = word;
      endcase
      return result;
   endfunction

   // A new instruction can enter whenever nothing is outstanding on the LSU;
   // taking one during WRITE is what keeps ALU ops flowing one per cycle.
   assign in_ready   = (state_q == IDLE) || (state_q == WRITE);
   assign lsu_rready = (state_q == WAIT_LD);
   assign accept     = in_valid && in_ready;

   // Next-state and field update. Acceptance is applied last so that an
   // instruction arriving in the WRITE cycle overrides the return to IDLE.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      rd_d      = rd_q;
      wen_d     = wen_q;
      data_d    = data_q;
      func_d    = func_q;
      lo_d      = lo_q;
      err_d     = err_q;
      last_pc_d = last_pc_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         WAIT_LD: begin
            if (lsu_rvalid) begin
               data_d  = loadExtend(func_q, lo_q, lsu_rdata);
               err_d   = lsu_rerr;
               state_d = WRITE;
            end
         end
         WRITE: begin
            last_pc_d = pc_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         pc_d   = in_pc;
         rd_d   = in_rd;
         wen_d  = in_wen;
         func_d = in_ld_func;
         lo_d   = in_addr_lo;
         err_d  = 1'b0;
         data_d = in_data;
         if (in_is_load) begin
            state_d = WAIT_LD;
         end else begin
            state_d = WRITE;
         end
      end
   end

   // State and held-instruction registers. Reset drops any in-flight load, so
   // a response arriving afterwards finds the unit in IDLE and is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         data_q    <= '0;
         func_q    <= '0;
         lo_q      <= '0;
         err_q     <= 1'b0;
         last_pc_q <= RST_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         data_q    <= data_d;
         func_q    <= func_d;
         lo_q      <= lo_d;
         err_q     <= err_d;
         last_pc_q <= last_pc_d;
      end
   end

   // Commit and RF write happen only in WRITE. A faulted load and writes to
   // x0 still commit but never raise rfwen. commit_pc keeps showing the last
   // retired PC between commits, starting from the reset vector.
   assign commit_valid = (state_q == WRITE);
   assign commit_pc    = commit_valid ? pc_q : last_pc_q;
   assign rfwen        = commit_valid && wen_q && (rd_q != 5'd0) && !err_q;
   assign load_err     = commit_valid && err_q;
   assign w1a          = rd_q;
   assign w1d          = data_q;

   // Hazard hints: the held instruction will still write a real register.
   assign wb_busy = (state_q != IDLE) && wen_q && (rd_q != 5'd0);
   assign wb_rd   = rd_q;

endmodule

// File: tb/tb_ysyx_23060020_wbu.sv
// Self-checking bench for the writeback unit: a vector table of ALU and load
// cases feeds a scoreboard that is checked on every commit, plus hand-written
// sequences for back-to-back flow, load stalls, stray responses and reset.
module tb_ysyx_23060020_wbu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic [31:0] in_data;
   logic        in_is_load;
   logic [2:0]  in_ld_func;
   logic [1:0]  in_addr_lo;
   logic        lsu_rvalid;
   logic        lsu_rready;
   logic [31:0] lsu_rdata;
   logic        lsu_rerr;
   logic        rfwen;
   logic [4:0]  w1a;
   logic [31:0] w1d;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        load_err;
   logic        wb_busy;
   logic [4:0]  wb_rd;

   typedef struct {
      logic        isLoad;
      logic [2:0]  func;
      logic [1:0]  lo;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
      logic [31:0] rdata;
      logic        rerr;
      logic        expRfwen;
      logic [31:0] expW1d;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        rfwen;
      logic [4:0]  rd;
      logic [31:0] w1d;
      logic        err;
   } exp_t;

   localparam int NUM_VECS = 14;
   localparam logic [31:0] RDATA = 32'h80FF_7F01;

   vec_t vecs [NUM_VECS];
   exp_t sbQueue [$];

   int checks;
   int errors;
   int commitCount;
   int startCount;

   ysyx_23060020_wbu dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_rd        (in_rd),
      .in_wen       (in_wen),
      .in_data      (in_data),
      .in_is_load   (in_is_load),
      .in_ld_func   (in_ld_func),
      .in_addr_lo   (in_addr_lo),
      .lsu_rvalid   (lsu_rvalid),
      .lsu_rready   (lsu_rready),
      .lsu_rdata    (lsu_rdata),
      .lsu_rerr     (lsu_rerr),
      .rfwen        (rfwen),
      .w1a          (w1a),
      .w1d          (w1d),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .load_err     (load_err),
      .wb_busy      (wb_busy),
      .wb_rd        (wb_rd)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor: every commit pops the oldest expected record; outside
   // commits the write enable and fault flag must stay low.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (commit_valid === 1'b1) begin
         commitCount++;
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_commit: got pc %h, expected no commit", commit_pc);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("commit_pc", commit_pc, e.pc);
            checkOutput("rfwen", 32'(rfwen), 32'(e.rfwen));
            checkOutput("load_err", 32'(load_err), 32'(e.err));
            if (e.rfwen) begin
               checkOutput("w1a", 32'(w1a), 32'(e.rd));
               checkOutput("w1d", w1d, e.w1d);
            end
         end
      end else begin
         checkOutput("rfwen_outside_write", 32'(rfwen), 32'd0);
         checkOutput("load_err_outside_write", 32'(load_err), 32'd0);
      end
   end

   // Drives one instruction (and its LSU response for loads), queues the
   // expected commit, and checks the one-cycle write latency.
   task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
      @(negedge clk);
      in_valid   = 1'b1;
      in_pc      = pc;
      in_rd      = v.rd;
      in_wen     = v.wen;
      in_data    = v.data;
      in_is_load = v.isLoad;
      in_ld_func = v.func;
      in_addr_lo = v.lo;
      checkOutput("in_ready_accept", 32'(in_ready), 32'd1);
      sbQueue.push_back('{pc, v.expRfwen, v.rd, v.expW1d, v.expErr});
      @(posedge clk);
      #2;
      if (!v.isLoad) checkOutput("alu_latency", 32'(commit_valid), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'h0BAD_0BAD;
      if (v.isLoad) begin
         checkOutput("lsu_rready_wait", 32'(lsu_rready), 32'd1);
         lsu_rvalid = 1'b1;
         lsu_rdata  = v.rdata;
         lsu_rerr   = v.rerr;
         @(posedge clk);
         #2;
         checkOutput("load_latency", 32'(commit_valid), 32'd1);
         @(negedge clk);
         lsu_rvalid = 1'b0;
         lsu_rerr   = 1'b0;
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      commitCount = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_pc       = '0;
      in_rd       = '0;
      in_wen      = 1'b0;
      in_data     = '0;
      in_is_load  = 1'b0;
      in_ld_func  = '0;
      in_addr_lo  = '0;
      lsu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_rerr    = 1'b0;

      //           isLoad func    lo     rd     wen   data           rdata  rerr  expRfwen expW1d         expErr
      vecs[0]  = '{1'b0, 3'b000, 2'd0, 5'd5,  1'b1, 32'h0000_1234, '0,    1'b0, 1'b1, 32'h0000_1234, 1'b0};
      vecs[1]  = '{1'b0, 3'b000, 2'd0, 5'd0,  1'b1, 32'hFFFF_FFFF, '0,    1'b0, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{1'b0, 3'b000, 2'd0, 5'd7,  1'b0, 32'hDEAD_BEEF, '0,    1'b0, 1'b0, 32'h0,         1'b0};
      vecs[3]  = '{1'b1, 3'b000, 2'd3, 5'd1,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0};
      vecs[4]  = '{1'b1, 3'b100, 2'd1, 5'd2,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h0000_007F, 1'b0};
      vecs[5]  = '{1'b1, 3'b001, 2'd2, 5'd3,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'hFFFF_80FF, 1'b0};
      vecs[6]  = '{1'b1, 3'b101, 2'd0, 5'd4,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h0000_7F01, 1'b0};
      vecs[7]  = '{1'b1, 3'b010, 2'd0, 5'd6,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h80FF_7F01, 1'b0};
      vecs[8]  = '{1'b1, 3'b011, 2'd1, 5'd8,  1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h80FF_7F01, 1'b0};
      vecs[9]  = '{1'b1, 3'b000, 2'd0, 5'd10, 1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
      vecs[10] = '{1'b1, 3'b001, 2'd3, 5'd11, 1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'hFFFF_80FF, 1'b0};
      vecs[11] = '{1'b1, 3'b100, 2'd2, 5'd13, 1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h0000_00FF, 1'b0};
      vecs[12] = '{1'b1, 3'b101, 2'd3, 5'd14, 1'b1, 32'hAAAA_5555, RDATA, 1'b0, 1'b1, 32'h0000_80FF, 1'b0};
      vecs[13] = '{1'b1, 3'b010, 2'd0, 5'd12, 1'b1, 32'hAAAA_5555, RDATA, 1'b1, 1'b0, 32'h0,         1'b1};

      // Reset values while reset is held and just after release.
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_lsu_rready", 32'(lsu_rready), 32'd0);
      checkOutput("rst_commit_valid", 32'(commit_valid), 32'd0);
      checkOutput("rst_commit_pc", commit_pc, 32'h8000_0000);
      checkOutput("rst_wb_busy", 32'(wb_busy), 32'd0);
      checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_commit_pc", commit_pc, 32'h8000_0000);

      // Vector table: ALU, x0, no-write, every load flavour, faulted load.
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i], 32'h8000_1000 + 32'(i) * 32'd4);
      end

      // Four ALU ops on consecutive cycles with in_valid held high.
      startCount = commitCount;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_is_load = 1'b0;
         in_wen     = 1'b1;
         in_rd      = 5'(16 + i);
         in_data    = 32'h0000_1000 + 32'(i);
         in_pc      = 32'h9000_0000 + 32'(i) * 32'd4;
         checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
         sbQueue.push_back('{in_pc, 1'b1, in_rd, in_data, 1'b0});
         @(posedge clk);
         #2;
         checkOutput("b2b_commit", 32'(commit_valid), 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b_count", 32'(commitCount - startCount), 32'd4);

      // Load whose response arrives five cycles late.
      @(negedge clk);
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_ld_func = 3'b010;
      in_addr_lo = 2'd0;
      in_wen     = 1'b1;
      in_rd      = 5'd20;
      in_pc      = 32'hA000_0000;
      sbQueue.push_back('{32'hA000_0000, 1'b1, 5'd20, 32'h1234_5678, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
         checkOutput("stall_wb_busy", 32'(wb_busy), 32'd1);
         checkOutput("stall_wb_rd", 32'(wb_rd), 32'd20);
         checkOutput("stall_no_commit", 32'(commit_valid), 32'd0);
         @(negedge clk);
      end
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'h1234_5678;
      @(posedge clk);
      #2;
      checkOutput("stall_commit", 32'(commit_valid), 32'd1);
      @(negedge clk);
      lsu_rvalid = 1'b0;

      // Stray LSU response while idle must be ignored.
      @(negedge clk);
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      lsu_rvalid = 1'b0;
      checkOutput("stray_in_ready", 32'(in_ready), 32'd1);
      checkOutput("stray_lsu_rready", 32'(lsu_rready), 32'd0);
      checkOutput("stray_wb_busy", 32'(wb_busy), 32'd0);

      // Reset while a load waits: load is dropped, late response ignored.
      startCount = commitCount;
      @(negedge clk);
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_ld_func = 3'b000;
      in_rd      = 5'd9;
      in_wen     = 1'b1;
      in_pc      = 32'hB000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("pre_rst_lsu_rready", 32'(lsu_rready), 32'd1);
      checkOutput("pre_rst_wb_busy", 32'(wb_busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_rst_lsu_rready", 32'(lsu_rready), 32'd0);
      checkOutput("async_rst_wb_busy", 32'(wb_busy), 32'd0);
      checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("async_rst_commit_pc", commit_pc, 32'h8000_0000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      lsu_rvalid = 1'b1;
      lsu_rdata  = RDATA;
      @(negedge clk);
      lsu_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_drop_no_commit", 32'(commitCount - startCount), 32'd0);

      checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
